// File: rtl/histo_pkg.sv
// histo_pkg: shared constants, FSM states and header packing for the histogram TX path.
package histo_pkg;

    localparam logic [7:0] HDR_SYNC = 8'hA5;
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_CAM_LSB = 20;
    localparam int HDR_SEQ_LSB = 0;
    localparam int DEF_NUM_BINS = 1024;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_STREAM, ST_DRAIN} state_t;

    function automatic logic [31:0] make_hdr(input logic [3:0] cam, input logic [15:0] seq);
        logic [31:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8] = HDR_SYNC;
        h[HDR_CAM_LSB +: 4] = cam;
        h[HDR_SEQ_LSB +: 16] = seq;
        return h;
    endfunction

endpackage

// File: rtl/histo_rr_arbiter.sv
// histo_rr_arbiter: combinational round-robin pick of the lowest request at or above ptr, wrapping.
module histo_rr_arbiter import histo_pkg::*; #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] grant,
    output logic [3:0]   idx,
    output logic         valid
);

    always_comb begin
        grant = '0;
        idx = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++)
            if (!valid && req[i] && i >= int'(ptr)) begin
                grant[i] = 1'b1;
                idx = 4'(i);
                valid = 1'b1;
            end
        for (int i = 0; i < N; i++)
            if (!valid && req[i]) begin
                grant[i] = 1'b1;
                idx = 4'(i);
                valid = 1'b1;
            end
    end

endmodule

// File: rtl/histo_tx_scheduler.sv
// histo_tx_scheduler: frames one camera histogram (header, bins, checksum) into the
// serializer word input, arbitrating round-robin between cameras.
module histo_tx_scheduler import histo_pkg::*; #(
    parameter int NUM_CAM = 2,
    parameter int NUM_BINS = DEF_NUM_BINS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    fast_clk_in,
    input  logic                    reset,
    input  logic [NUM_CAM-1:0]      frame_ready,
    output logic [NUM_CAM-1:0]      frame_ack,
    output logic [ADDR_W-1:0]       bin_addr,
    output logic [NUM_CAM-1:0]      bin_rd_en,
    input  logic [32*NUM_CAM-1:0]   bin_rdata,
    output logic [31:0]             ser_data,
    output logic                    ser_rst,
    input  logic                    ser_done,
    output logic                    busy,
    output logic [3:0]              active_cam,
    output logic                    err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t state;
    logic [NUM_CAM-1:0] gnt, arb_grant;
    logic [3:0] arb_idx, rr, rr_next;
    logic arb_valid, rd_pend, timed_out;
    logic [31:0] rdata, pref, csum, hdr;
    logic [15:0] frame_seq;
    logic [ADDR_W:0] widx;
    logic [TW-1:0] tcnt;

    histo_rr_arbiter #(.N(NUM_CAM)) u_arb (
        .req(frame_ready),
        .ptr(rr),
        .grant(arb_grant),
        .idx(arb_idx),
        .valid(arb_valid)
    );

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CAM; i++)
            rdata = (active_cam == 4'(i)) ? bin_rdata[32*i +: 32] : rdata;
    end

    assign hdr = make_hdr(active_cam, frame_seq);
    assign rr_next = (int'(active_cam) + 1 >= NUM_CAM) ? 4'd0 : active_cam + 4'd1;
    assign timed_out = (state == ST_STREAM || state == ST_DRAIN) && int'(tcnt) == TIMEOUT_CYC;

    // widx walks header (0), bins (1..NUM_BINS), footer (NUM_BINS+1); bin k+1 is fetched as bin k launches
    always_ff @(posedge fast_clk_in) begin
        if (reset) begin
            state <= ST_IDLE;
            ser_rst <= 1'b1;
            ser_data <= '0;
            frame_ack <= '0;
            bin_rd_en <= '0;
            bin_addr <= '0;
            busy <= 1'b0;
            active_cam <= '0;
            err_timeout <= 1'b0;
            rr <= '0;
            frame_seq <= '0;
            gnt <= '0;
            rd_pend <= 1'b0;
            pref <= '0;
            csum <= '0;
            widx <= '0;
            tcnt <= '0;
        end else begin
            frame_ack <= '0;
            bin_rd_en <= '0;
            rd_pend <= |bin_rd_en;
            if (rd_pend)
                pref <= rdata;
            if (timed_out || (state == ST_DRAIN && ser_done)) begin
                ser_rst <= 1'b1;
                frame_ack <= gnt;
                rr <= rr_next;
                busy <= 1'b0;
                err_timeout <= err_timeout | timed_out;
                frame_seq <= timed_out ? frame_seq : frame_seq + 16'd1;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (arb_valid) begin
                        gnt <= arb_grant;
                        active_cam <= arb_idx;
                        busy <= 1'b1;
                        bin_addr <= '0;
                        bin_rd_en <= arb_grant;
                        tcnt <= '0;
                        state <= ST_PREFETCH;
                    end
                    ST_PREFETCH: if (rd_pend) begin
                        ser_rst <= 1'b0;
                        widx <= '0;
                        state <= ST_STREAM;
                    end
                    ST_STREAM: if (ser_done) begin
                        tcnt <= '0;
                        widx <= widx + 1'b1;
                        if (widx == '0) begin
                            ser_data <= hdr;
                            csum <= hdr;
                        end else if (int'(widx) <= NUM_BINS) begin
                            ser_data <= pref;
                            csum <= csum + pref;
                            if (int'(widx) < NUM_BINS) begin
                                bin_addr <= widx[ADDR_W-1:0];
                                bin_rd_en <= gnt;
                            end
                        end else begin
                            ser_data <= csum;
                            state <= ST_DRAIN;
                        end
                    end else
                        tcnt <= tcnt + 1'b1;
                    ST_DRAIN: tcnt <= tcnt + 1'b1;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_histo_tx_scheduler.sv
// tb_histo_tx_scheduler: frame scoreboard with serializer and bin-memory models for histo_tx_scheduler.
module tb_histo_tx_scheduler;

    localparam int NC = 2;
    localparam int NB = 1024;
    localparam int AW = 10;
    localparam int TO = 1024;

    typedef struct {
        bit          rst;
        logic [1:0]  ready;
        int          pat;
        int          drop_at;
        bit          chk_lat;
        logic [1:0]  ack;
        logic [31:0] hdr;
        logic [31:0] ftr;
    } row_t;

    logic fast_clk_in = 1'b0;
    logic reset = 1'b1;
    logic ser_done = 1'b0;
    logic [NC-1:0] frame_ready = '0;
    logic [32*NC-1:0] bin_rdata = '0;
    logic [NC-1:0] frame_ack, bin_rd_en;
    logic [AW-1:0] bin_addr;
    logic [31:0] ser_data;
    logic ser_rst, busy, err_timeout;
    logic [3:0] active_cam;

    logic [31:0] wq[$];
    logic [1:0] aq[$];
    int n_vec = 0, n_err = 0, cyc = 0, wcnt = 0, last_wcnt = 0, last_done = 0;
    int ack_cnt = 0, stall_at = -1, cur_pat = 0;
    row_t rows[6];
    row_t post;

    histo_tx_scheduler #(.NUM_CAM(NC), .NUM_BINS(NB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .fast_clk_in(fast_clk_in),
        .reset(reset),
        .frame_ready(frame_ready),
        .frame_ack(frame_ack),
        .bin_addr(bin_addr),
        .bin_rd_en(bin_rd_en),
        .bin_rdata(bin_rdata),
        .ser_data(ser_data),
        .ser_rst(ser_rst),
        .ser_done(ser_done),
        .busy(busy),
        .active_cam(active_cam),
        .err_timeout(err_timeout)
    );

    initial forever #5 fast_clk_in = ~fast_clk_in;

    function automatic logic [31:0] bin_val(input int pat, input int cam, input int k);
        return (pat != 0) ? 32'hFFFFFFFF : (32'(k) | (32'(cam) << 16));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Registered bin memory: data for a read strobe appears one cycle later, garbage otherwise
    initial begin
        logic [NC-1:0] pend;
        logic [AW-1:0] paddr;
        pend = '0;
        paddr = '0;
        forever begin
            @(negedge fast_clk_in);
            for (int c = 0; c < NC; c++)
                bin_rdata[32*c +: 32] = pend[c] ? bin_val(cur_pat, c, int'(paddr)) : 32'hDEADBEEF;
            pend = bin_rd_en;
            paddr = bin_addr;
        end
    end

    // Serializer model (one word every 4 cycles) plus word and ack scoreboard
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge fast_clk_in);
            cyc++;
            if (reset) begin
                wq.delete();
                wcnt = 0;
                ph = 0;
                ser_done = 1'b0;
            end else begin
                if (ser_done) begin
                    last_done = cyc;
                    if (wq.size() > 0) begin
                        chk("ser_data", ser_data, wq.pop_front());
                        wcnt++;
                    end
                end
                if (frame_ack != '0) begin
                    if (aq.size() == 0)
                        chk("unexpected_ack", 32'(frame_ack), 32'd0);
                    else
                        chk("frame_ack", 32'(frame_ack), 32'(aq.pop_front()));
                    last_wcnt = wcnt;
                    wq.delete();
                    wcnt = 0;
                    ack_cnt++;
                end
                if (ser_rst || (stall_at >= 0 && wcnt >= stall_at)) begin
                    ser_done = 1'b0;
                    ph = 0;
                end else begin
                    ph = (ph == 3) ? 0 : ph + 1;
                    ser_done = (ph == 3);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge fast_clk_in);
        reset = 1'b1;
        frame_ready = '0;
        stall_at = -1;
        repeat (3) @(negedge fast_clk_in);
        reset = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_ser_rst", 32'(ser_rst), 32'd1);
        chk("rst_ser_data", ser_data, 32'd0);
        chk("rst_frame_ack", 32'(frame_ack), 32'd0);
        chk("rst_bin_rd_en", 32'(bin_rd_en), 32'd0);
        chk("rst_bin_addr", 32'(bin_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active_cam", 32'(active_cam), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    endtask

    task automatic push_frame(input int cam, input int pat, input logic [31:0] hdr, input logic [31:0] ftr);
        wq.push_back(hdr);
        for (int k = 0; k < NB; k++)
            wq.push_back(bin_val(pat, cam, k));
        wq.push_back(ftr);
    endtask

    task automatic run_frame(input row_t r);
        int a0, t;
        if (r.rst)
            do_reset();
        cur_pat = r.pat;
        push_frame(r.ack[1] ? 1 : 0, r.pat, r.hdr, r.ftr);
        aq.push_back(r.ack);
        a0 = ack_cnt;
        @(negedge fast_clk_in);
        frame_ready = r.ready;
        if (r.chk_lat) begin
            t = 0;
            while (ser_rst && t < 10) begin
                @(negedge fast_clk_in);
                t++;
            end
            chk("rst_latency", 32'(t), 32'd3);
        end
        t = 0;
        while (ack_cnt == a0 && t < 6000) begin
            @(negedge fast_clk_in);
            t++;
            if (r.drop_at >= 0 && wcnt >= r.drop_at)
                frame_ready = '0;
        end
        chk("frame_done", 32'(ack_cnt - a0), 32'd1);
        chk("frame_words", 32'(last_wcnt), 32'(NB + 2));
    endtask

    initial begin
        int a0, t, d;
        rows[0] = '{1'b1, 2'b01, 0, 5, 1'b1, 2'b01, 32'hA5000000, 32'hA507FE00};
        rows[1] = '{1'b1, 2'b11, 0, -1, 1'b1, 2'b01, 32'hA5000000, 32'hA507FE00};
        rows[2] = '{1'b0, 2'b11, 0, -1, 1'b0, 2'b10, 32'hA5100001, 32'hA917FE01};
        rows[3] = '{1'b0, 2'b11, 0, -1, 1'b0, 2'b01, 32'hA5000002, 32'hA507FE02};
        rows[4] = '{1'b0, 2'b11, 0, 1, 1'b0, 2'b10, 32'hA5100003, 32'hA917FE03};
        rows[5] = '{1'b0, 2'b01, 1, 2, 1'b1, 2'b01, 32'hA5000004, 32'hA4FFFC04};
        post = '{1'b0, 2'b01, 0, 3, 1'b1, 2'b01, 32'hA5000000, 32'hA507FE00};

        do_reset();
        chk_reset();
        foreach (rows[i])
            run_frame(rows[i]);
        chk("no_err_timeout", 32'(err_timeout), 32'd0);

        // serializer stalls after 11 words: abort, ack, sticky error, sequence not consumed
        do_reset();
        cur_pat = 0;
        push_frame(0, 0, 32'hA5000000, 32'hA507FE00);
        aq.push_back(2'b01);
        stall_at = 11;
        a0 = ack_cnt;
        @(negedge fast_clk_in);
        frame_ready = 2'b01;
        t = 0;
        while (!err_timeout && t < 3000) begin
            @(negedge fast_clk_in);
            t++;
            if (wcnt >= 2)
                frame_ready = '0;
        end
        d = cyc - last_done;
        chk("err_timeout_set", 32'(err_timeout), 32'd1);
        chk("timeout_window", 32'(d >= TO - 1 && d <= TO + 3), 32'd1);
        chk("abort_ser_rst", 32'(ser_rst), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge fast_clk_in);
        chk("abort_ack", 32'(ack_cnt - a0), 32'd1);
        chk("abort_words", 32'(last_wcnt), 32'd11);
        stall_at = -1;
        run_frame(post);
        chk("err_sticky", 32'(err_timeout), 32'd1);

        // reset in the middle of the bins: immediate reset values, no ack, fresh frame after
        do_reset();
        cur_pat = 0;
        push_frame(0, 0, 32'hA5000000, 32'hA507FE00);
        a0 = ack_cnt;
        @(negedge fast_clk_in);
        frame_ready = 2'b01;
        t = 0;
        while (wcnt < 501 && t < 4000) begin
            @(negedge fast_clk_in);
            t++;
            if (wcnt >= 2)
                frame_ready = '0;
        end
        chk("reached_bin500", 32'(wcnt >= 501), 32'd1);
        reset = 1'b1;
        @(negedge fast_clk_in);
        chk_reset();
        @(negedge fast_clk_in);
        reset = 1'b0;
        repeat (5) @(negedge fast_clk_in);
        chk("no_ack_on_reset", 32'(ack_cnt - a0), 32'd0);
        run_frame(post);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/histo_tx_scheduler.md
Name: histo_tx_scheduler

Overview:
Frame-level controller for the histogram byte serializer. Arbitrates round-robin between NUM_CAM per-camera histogram buffers and reads the granted buffer's bins. Presents the serializer's 32-bit word input as one frame: header, NUM_BINS bins, then a checksum footer. Holds the serializer in reset between frames and signals frame completion back to the buffer owner.

Parameters:
NUM_CAM, 2, number of histogram sources (1..16)
NUM_BINS, 1024, bins per frame
ADDR_W, 10, bin address width (clog2(NUM_BINS))
TIMEOUT_CYC, 1024, max cycles between ser_done pulses before abort

Ports:
fast_clk_in  in  1  clock
reset  in  1  synchronous, active-high
frame_ready  in  NUM_CAM  level; source i has a complete histogram
frame_ack  out  NUM_CAM  one-cycle pulse; frame from source i fully sent or aborted
bin_addr  out  ADDR_W  bin read address, common to all sources
bin_rd_en  out  NUM_CAM  one-hot read strobe to granted source
bin_rdata  in  32*NUM_CAM  flattened read data, 1-cycle latency after bin_rd_en
ser_data  out  32  word to serializer data_in
ser_rst  out  1  serializer reset (high = held idle)
ser_done  in  1  serializer word-boundary pulse
busy  out  1  frame in progress
active_cam  out  4  index of granted source
err_timeout  out  1  sticky; set on ser_done timeout, cleared only by reset

Behaviour:
- Reset: state IDLE, ser_rst=1, ser_data=0, frame_ack=0, bin_rd_en=0, bin_addr=0, busy=0, active_cam=0, err_timeout=0, rr pointer=0, frame_seq=0.
- ser_done semantics: each pulse means the serializer starts byte 0 of ser_data on the next cycle. ser_data is loaded with the next word on the same edge that ser_done is sampled high. The first ser_done after ser_rst falls loads the header. The ser_done after the footer is loaded means the footer has been launched.
- State machine:
  - IDLE: if any frame_ready, grant the lowest index at or above the rr pointer (wrapping), latch active_cam, set busy. -> PREFETCH.
  - PREFETCH: issue bin_rd_en for addr 0, capture bin_rdata next cycle into the prefetch register, drop ser_rst. -> STREAM.
  - STREAM, word sequence: header = {8'hA5, active_cam[3:0], 4'h0, frame_seq[15:0]}; bins 0..NUM_BINS-1; footer = checksum.
    - On each ser_done, load the next word and immediately issue a read for the following bin (addr+1). The prefetch register is refilled within 2 cycles, well inside one word time.
    - After the footer is loaded, -> DRAIN.
  - DRAIN: on ser_done, assert ser_rst, pulse frame_ack[active_cam], increment frame_seq (16-bit wrap), advance the rr pointer to active_cam+1 mod NUM_CAM, clear busy. -> IDLE.
- Checksum: 32-bit wrapping sum of the header and all bin words. Accumulated as each word is loaded.
- Timeout: counter cleared on every ser_done and on entry to PREFETCH. If it reaches TIMEOUT_CYC while in STREAM or DRAIN: set err_timeout, assert ser_rst, pulse frame_ack (frame lost), do not increment frame_seq, advance rr, -> IDLE.
- frame_ready dropping mid-frame is ignored; the frame completes. frame_ready still high after ack makes the source eligible again under round-robin.
- Simultaneous requests: strict round-robin, so no source is granted twice while another is waiting.
- A ser_done seen in IDLE or PREFETCH is ignored.
- Reset mid-frame aborts immediately to the reset values. No frame_ack is issued.
- Latency: frame_ready to ser_rst falling is 3 cycles.

Decomposition:
- Shared package (histo_pkg): HDR_SYNC=8'hA5, state enum, HDR field positions, default NUM_BINS/ADDR_W.
- Sub-module: histo_rr_arbiter (request vector plus pointer in, one-hot grant plus index out, combinational). Keep it separate for reuse by the readout path.

Test Plan:
1. frame_ready=01, bins[k]=k, serializer model -> header 0xA5000000, words 0..1023, footer 0xA5000000+523776=0xA507FE00; frame_ack=01 pulse; frame_seq=1.
2. frame_ready=11 held for 4 frames -> grant order cam0, cam1, cam0, cam1; headers carry frame_seq 0,1,2,3; frame_ack alternates.
3. Serializer model stops pulsing ser_done after word 10 -> err_timeout=1 after TIMEOUT_CYC cycles, ser_rst=1, frame_ack pulse; next frame header still uses frame_seq=0.
4. reset asserted during bin 500 -> next cycle all outputs at reset values with no frame_ack; the following frame starts with header and frame_seq=0.
5. frame_ready[0] dropped at bin 3 -> full 1026-word frame still sent and frame_ack[0] pulses.
6. bin values 0xFFFFFFFF on all bins -> footer equals the wrapped 32-bit sum; check against the reference model.
